// File: rtl/aes_result_serializer_pkg.sv
// Shared types, sizing constants and beat-selection helper for the AES result serializer.
// The default datapath is a 128-bit block streamed as 8-bit beats.
package aes_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    localparam int SER_DATA_W = 128;
    localparam int SER_OUT_W  = 8;
    localparam int NB         = SER_DATA_W / SER_OUT_W;
    // One spare count value so a trailing checksum beat still fits.
    localparam int CNT_W      = $clog2(NB + 1);

    // Return beat number idx of a block, counted from the MSB end or the LSB end.
    function automatic logic [SER_OUT_W-1:0] beat_sel(
        input logic [SER_DATA_W-1:0] data,
        input int                    idx,
        input logic                  msb_first
    );
        logic [SER_OUT_W-1:0] beat;
        if (msb_first) begin
            beat = data[SER_DATA_W - 1 - idx * SER_OUT_W -: SER_OUT_W];
        end else begin
            beat = data[idx * SER_OUT_W +: SER_OUT_W];
        end
        return beat;
    endfunction

endpackage

// File: rtl/aes_result_serializer_xor_fold.sv
// XOR reduction of a wide block down to one beat (the frame checksum).
// Only compiled when AES_SER_CKSUM_EN is defined; the default build has no checksum logic.
`ifdef AES_SER_CKSUM_EN
module xor_fold #(
    parameter int DATA_W = 128,
    parameter int OUT_W  = 8
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [OUT_W-1:0]  fold_o
);

    localparam int SLICES = DATA_W / OUT_W;

    // XOR every OUT_W-wide slice together; slice order does not matter.
    always_comb begin
        fold_o = {OUT_W{1'b0}};
        for (int i = 0; i < SLICES; i++) begin
            fold_o = fold_o ^ data_i[i * OUT_W +: OUT_W];
        end
    end

endmodule
`endif

// File: rtl/aes_result_serializer.sv
// Captures one ciphertext block and streams it out as OUT_W-bit beats with valid/ready
// on both sides. A new block may be accepted on the edge that retires the last beat,
// so consecutive frames run without idle cycles.
// Optional feature macro: AES_SER_CKSUM_EN appends one XOR-checksum beat per frame.
module aes_result_serializer
    import aes_ser_pkg::*;
#(
    parameter int DATA_W    = SER_DATA_W,
    parameter int OUT_W     = SER_OUT_W,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);

`ifdef AES_SER_CKSUM_EN
    localparam int TOTAL = NB + 1;
    localparam logic [CNT_W-1:0] DATA_LAST_IDX = CNT_W'(NB - 1);
`else
    localparam int TOTAL = NB;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
    localparam logic             MSB_SEL  = (MSB_FIRST != 0);

    ser_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               in_ready_s;
    logic               load_s;
    logic               accept_s;
    logic [DATA_W-1:0]  shifted_s;
    logic [CNT_W-1:0]   cnt_inc_s;

`ifdef AES_SER_CKSUM_EN
    logic [OUT_W-1:0]   cksum_q, cksum_d;
    logic [OUT_W-1:0]   fold_s;

    xor_fold #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_xor_fold (
        .data_i (in_data),
        .fold_o (fold_s)
    );
`endif

    // Accept a block when idle, or when the final beat is retiring this very edge.
    always_comb begin
        case (state_q)
            IDLE:    in_ready_s = 1'b1;
            SEND:    in_ready_s = out_last_q & out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign load_s    = in_valid & in_ready_s;
    assign accept_s  = out_valid_q & out_ready;
    assign shifted_s = MSB_SEL ? (shreg_q << OUT_W) : (shreg_q >> OUT_W);
    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Next-state logic: capture, advance one beat, retire the frame, or hold on a stall.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef AES_SER_CKSUM_EN
        cksum_d     = cksum_q;
`endif
        if (load_s) begin
            // Capture edge: beat 0 is presented on the very next cycle.
            state_d     = SEND;
            cnt_d       = CNT_W'(0);
            shreg_d     = in_data;
            out_data_d  = beat_sel(in_data, 0, MSB_SEL);
            out_valid_d = 1'b1;
            out_last_d  = (LAST_IDX == CNT_W'(0));
`ifdef AES_SER_CKSUM_EN
            cksum_d     = fold_s;
`endif
        end else if (accept_s) begin
            if (out_last_q) begin
                state_d     = IDLE;
                cnt_d       = CNT_W'(0);
                out_data_d  = {OUT_W{1'b0}};
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                cnt_d      = cnt_inc_s;
                shreg_d    = shifted_s;
                out_last_d = (cnt_inc_s == LAST_IDX);
`ifdef AES_SER_CKSUM_EN
                if (cnt_q == DATA_LAST_IDX) begin
                    out_data_d = cksum_q;
                end else begin
                    out_data_d = beat_sel(shifted_s, 0, MSB_SEL);
                end
`else
                out_data_d = beat_sel(shifted_s, 0, MSB_SEL);
`endif
            end
        end else begin
            // Idle with nothing offered, or stalled: everything holds.
            state_d = state_q;
        end
    end

    // State, counter, shift register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_W'(0);
            shreg_q     <= {DATA_W{1'b0}};
            out_data_q  <= {OUT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef AES_SER_CKSUM_EN
            cksum_q     <= {OUT_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef AES_SER_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_aes_result_serializer.sv
// Bench for aes_result_serializer: directed cases plus randomized traffic, with a
// byte-level scoreboard fed at block acceptance and drained by an independent monitor.
// Compile with AES_SER_CKSUM_EN defined to exercise the checksum beat.
module tb_aes_result_serializer;

    localparam int NBB = 16;
`ifdef AES_SER_CKSUM_EN
    localparam int TOT = NBB + 1;
`else
    localparam int TOT = NBB;
`endif
    localparam logic [127:0] BLK_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         clk_en = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_last;
    logic         out_ready;
    logic         busy;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    aes_result_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: a frame is the block's bytes taken MSB first, plus the XOR of
    // all bytes when the checksum beat is enabled; the final beat carries last.
    task automatic push_block(input logic [127:0] b);
        logic [7:0] x;
        logic [7:0] by;
        x = 8'h00;
        for (int i = 0; i < NBB; i++) begin
            by = b[127 - 8 * i -: 8];
            x  = x ^ by;
            exp_q.push_back('{d: by, l: (i == TOT - 1)});
        end
`ifdef AES_SER_CKSUM_EN
        exp_q.push_back('{d: x, l: 1'b1});
`endif
    endtask

    // One clock cycle of stimulus; inputs change on the falling edge.
    task automatic cycle(input logic iv, input logic [127:0] id, input logic ordy, output logic took);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        took = iv && in_ready;
        if (took) push_block(id);
        @(negedge clk);
    endtask

    // Drain with out_ready=1 until the frame is done, bounded.
    task automatic drain(input string name);
        logic t;
        int   n;
        n = 0;
        while (busy && n < 100) begin
            cycle(1'b0, 128'd0, 1'b1, t);
            n++;
        end
        chk({name, "_drain_done"}, busy, 1'b0);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    logic [7:0] prev_d;
    logic       prev_l;
    logic       prev_stall = 1'b0;
    beat_t      e;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, prev_d);
                chk("hold_last", out_last, prev_l);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e.d);
                    chk("beat_last", out_last, e.l);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
        end
    end

    initial begin
        logic took;
        int   n;
        in_valid  = 1'b0;
        in_data   = 128'd0;
        out_ready = 1'b0;
        rst       = 1'b0;

        // 1. Reset with no clock running: outputs clear immediately.
        #3 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 2. Single frame at full rate: no bubbles, busy drops right after the last beat.
        cycle(1'b1, BLK_A, 1'b1, took);
        chk("t2_take", took, 1'b1);
        for (int i = 0; i < TOT; i++) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            chk("t2_no_bubble", out_valid, 1'b1);
            chk("t2_busy", busy, 1'b1);
            @(negedge clk);
        end
        #1;
        chk("t2_busy_drop", busy, 1'b0);
        chk("t2_valid_drop", out_valid, 1'b0);
        chk("t2_queue_empty", exp_q.size(), 0);

        // 3. Backpressure with out_ready pattern 1,0,0 repeating.
        cycle(1'b1, BLK_B, 1'b0, took);
        chk("t3_take", took, 1'b1);
        n = 0;
        while (busy && n < 200) begin
            cycle(1'b0, 128'd0, (n % 3) == 0, took);
            n++;
        end
        chk("t3_done", busy, 1'b0);
        chk("t3_queue_empty", exp_q.size(), 0);

        // 4. Back-to-back: new block offered while the last beat retires.
        cycle(1'b1, BLK_A, 1'b1, took);
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        while (!out_last && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t4_reached_last", out_last, 1'b1);
        in_valid = 1'b1;
        in_data  = BLK_B;
        #1;
        chk("t4_in_ready", in_ready, 1'b1);
        if (in_ready) push_block(BLK_B);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t4_no_gap", out_valid, 1'b1);
        chk("t4_first_beat", out_data, 8'h00);
        drain("t4");

        // 5. Reset mid-frame after five accepted beats; next frame starts at beat 0.
        cycle(1'b1, BLK_B, 1'b1, took);
        for (int i = 0; i < 5; i++) cycle(1'b0, 128'd0, 1'b1, took);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", out_valid, 1'b0);
        chk("t5_rst_data", out_data, 8'h00);
        chk("t5_rst_last", out_last, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, BLK_A, 1'b1, took);
        chk("t5_take", took, 1'b1);
        #1;
        chk("t5_beat0", out_data, 8'h69);
        drain("t5");

        // Randomized traffic: random blocks, offer rate and consumer readiness.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 3) == 0,
                  {$urandom(), $urandom(), $urandom(), $urandom()},
                  $urandom_range(0, 2) != 0, took);
        end
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
